// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from vga_timing_gen: DAC pins plus pixel coordinates for the colour mapper.
// Timing source drives through master; the colour mapper / DAC side uses slave.
interface vga_timing_gen_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;

  modport master (
    output VGA_CLK,
    output VGA_HS,
    output VGA_VS,
    output VGA_BLANK_N,
    output VGA_SYNC_N,
    output DrawX,
    output DrawY,
    output frame_start
  );

  modport slave (
    input VGA_CLK,
    input VGA_HS,
    input VGA_VS,
    input VGA_BLANK_N,
    input VGA_SYNC_N,
    input DrawX,
    input DrawY,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: halves Clk into the pixel cadence, runs h/v counters, drives DrawX/DrawY and sync/blank.
// Latency: DrawX/DrawY are the counter registers; sync/blank align with them (one extra pixel with VGA_SYNC_DELAY_EN).
// Backpressure: none, free-running; the colour mapper must consume coordinates every pixel.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_VISIBLE < 1 || V_VISIBLE < 1 ||
        H_SYNC < 1 || V_SYNC < 1 || H_FRONT < 0 || H_BACK < 0 ||
        V_FRONT < 0 || V_BACK < 0) begin : g_bad_geometry
      $error("vga_timing_gen: illegal geometry, totals must be 1..1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_en;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       blank_n_nxt;
  logic       hs_q;
  logic       vs_q;
  logic       blank_n_q;
  logic       frame_start_q;
  logic [10:0] hc_ext;
  logic [10:0] vc_ext;

  always_comb begin
    h_wrap = (hc == H_LAST);
    v_wrap = (vc == V_LAST);
    hc_nxt = hc;
    vc_nxt = vc;
    if (pix_en) begin
      if (h_wrap) begin
        hc_nxt = '0;
        vc_nxt = v_wrap ? '0 : vc + 10'd1;
      end else begin
        hc_nxt = hc + 10'd1;
      end
    end
  end

  // Sync/blank decode the next-state counters so they land on the same edge as DrawX/DrawY.
  always_comb begin
    hc_ext      = {1'b0, hc_nxt};
    vc_ext      = {1'b0, vc_nxt};
    hs_nxt      = !((hc_ext >= HS_START) && (hc_ext < HS_END));
    vs_nxt      = !((vc_ext >= VS_START) && (vc_ext < VS_END));
    blank_n_nxt = (hc_ext < H_VIS) && (vc_ext < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en        <= 1'b0;
      hc            <= '0;
      vc            <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pix_en        <= ~pix_en;
      hc            <= hc_nxt;
      vc            <= vc_nxt;
      hs_q          <= hs_nxt;
      vs_q          <= vs_nxt;
      blank_n_q     <= blank_n_nxt;
      frame_start_q <= pix_en && h_wrap && v_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // One pixel of lag to match a colour mapper with registered RGB.
  logic hs_d;
  logic vs_d;
  logic blank_n_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      blank_n_d <= 1'b0;
    end else if (pix_en) begin
      hs_d      <= hs_q;
      vs_d      <= vs_q;
      blank_n_d <= blank_n_q;
    end
  end

  assign vga.VGA_HS      = hs_d;
  assign vga.VGA_VS      = vs_d;
  assign vga.VGA_BLANK_N = blank_n_d;
`else
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
`endif

  assign vga.VGA_CLK     = pix_en;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.frame_start = frame_start_q;

endmodule
